nibble_unsort: RTL
==================

# nibble_unsort

Inverse stage for the 4-nibble sorter. It accepts a sorted 16-bit word plus an 8-bit permutation tag that records where each sorted nibble came from. It scatters the nibbles back to their original positions, one nibble per cycle, and presents the restored word on a valid/ready output. It sits downstream of the sorter, so ranked data can be returned to original order after processing. It also flags malformed tags and unsorted input.

## Interface
- No parameters. Nibble width is 4 and the slot count is 4, both fixed.
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk
- in_valid  input  1  in_data/in_perm valid
- in_ready  output  1  block can accept; high only in IDLE
- in_data  input  16  sorted word; slot k = bits [4k+3:4k], slot 0 smallest
- in_perm  input  8  bits [2k+1:2k] = original position (0..3) of sorted slot k
- out_valid  output  1  out_data/flags valid; high only in DONE
- out_ready  input  1  downstream accepts
- out_data  output  16  restored word; nibble p = bits [4p+3:4p]
- perm_err  output  1  in_perm was not a true permutation
- order_err  output  1  in_data slots were not non-decreasing

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready: capture in_data and in_perm, clear out_data and mark[3:0], set k=0, go to SCATTER.
  - SCATTER: each cycle, write nibble k of the captured data into out_data nibble perm_k, and set mark[perm_k]. Increment k (2-bit). When k==3 after the write, go to DONE.
  - DONE: out_valid=1. Hold out_data, perm_err and order_err stable. On out_ready, go to IDLE.
- order_err is computed from in_data at capture and registered: 1 if any slot k > slot k+1 (unsigned, k=0..2). Equal neighbours are legal.
- perm_err is registered on entry to DONE: 1 if mark != 4'hF.
- Duplicate targets: a later slot overwrites an earlier one. Positions never written stay 4'h0. The data is still delivered, with perm_err set.
- Errors do not stall or drop the word. Flags are informational only.
- in_valid outside IDLE is ignored; no capture occurs.
- out_data, perm_err and order_err are meaningful only while out_valid=1. They hold their last values in IDLE.

## Timing
- Reset: state=IDLE, k=0, mark=0, out_data=16'h0000, perm_err=0, order_err=0, out_valid=0.
  - in_ready=0 while reset is asserted, and 1 on the first cycle after release.
- Reset mid-SCATTER or mid-DONE: the word is discarded and no output handshake occurs. The block is in IDLE with reset values after that edge.
- Latency, with acceptance at edge N:
  - SCATTER writes occur at edges N+1 through N+4.
  - out_valid rises after edge N+4.
- Minimum interval between acceptances is 6 cycles: 4 SCATTER, 1 DONE with out_ready=1, 1 IDLE.
- in_ready falls after the acceptance edge and returns only in IDLE, after the output handshake completes.
- Back-pressure: DONE is held indefinitely while out_ready=0, with all outputs frozen.
- out_ready asserted in the same cycle out_valid rises completes the transfer at the next edge.

## Test plan
- Normal restore: in_data=16'h9531, in_perm=8'h8D -> after 5 cycles out_valid=1, out_data=16'h3915, perm_err=0, order_err=0.
- Identity tag: in_data=16'hFA50, in_perm=8'hE4 -> out_data=16'hFA50, perm_err=0, order_err=0. Equal nibbles are also legal, e.g. 16'h5550 with 8'hE4 -> order_err=0.
- Duplicate tag: in_data=16'h4321, in_perm=8'h00 -> out_data=16'h0004, perm_err=1, order_err=0.
- Unsorted input: in_data=16'h1234, in_perm=8'hE4 -> out_data=16'h1234, order_err=1, perm_err=0.
- Back-pressure and ignored input:
  - Stimulus: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new data.
  - Required response: out_data stable, in_ready=0, no capture.
  - After out_ready=1, the block returns to IDLE and the next word is accepted one cycle later.
- Reset at the second SCATTER cycle -> next cycle IDLE, in_ready=1, out_valid=0, out_data=16'h0000, no output transfer ever observed for that word.

Source files
------------

// File: rtl/nibble_unsort.sv
// nibble_unsort
//   Inverse stage for the 4-nibble sorter. It captures a sorted 16-bit word and
//   an 8-bit permutation tag. Over four cycles it scatters one nibble per cycle
//   back to its original position. It then presents the restored word on a
//   valid/ready output together with two informational error flags.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   in_valid   in_data/in_perm valid
//   in_ready   block can accept (IDLE only, low while reset is asserted)
//   in_data    sorted word, slot k = bits [4k+3:4k], slot 0 smallest
//   in_perm    bits [2k+1:2k] = original position of sorted slot k
//   out_valid  out_data/flags valid (DONE only)
//   out_ready  downstream accepts
//   out_data   restored word, nibble p = bits [4p+3:4p]
//   perm_err   tag was not a true permutation
//   order_err  input slots were not non-decreasing
module nibble_unsort (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [7:0]  in_perm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        perm_err,
  output logic        order_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCATTER = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  k_q;
  logic [3:0]  mark_q;
  logic [15:0] data_q;
  logic [7:0]  perm_q;
  logic [15:0] out_data_q;
  logic        perm_err_q;
  logic        order_err_q;
  logic        out_valid_q;

  logic [15:0] out_data_d;
  logic [3:0]  mark_d;
  logic [1:0]  tgt;
  logic [3:0]  nib;
  logic [2:0]  unsorted;

  // One comparator per adjacent slot pair; equal neighbours are legal.
  for (genvar gi = 0; gi < 3; gi++) begin : g_order
    assign unsorted[gi] = in_data[4*gi +: 4] > in_data[4*gi+4 +: 4];
  end

  // Scatter datapath for the current slot k. A later slot that targets the
  // same position simply overwrites the earlier nibble.
  always_comb begin
    tgt        = perm_q[{k_q, 1'b0} +: 2];
    nib        = data_q[{k_q, 2'b00} +: 4];
    out_data_d = out_data_q;
    out_data_d[{tgt, 2'b00} +: 4] = nib;
    mark_d     = mark_q | (4'b0001 << tgt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      mark_q      <= 4'h0;
      data_q      <= 16'h0000;
      perm_q      <= 8'h00;
      out_data_q  <= 16'h0000;
      perm_err_q  <= 1'b0;
      order_err_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q      <= in_data;
            perm_q      <= in_perm;
            out_data_q  <= 16'h0000;
            mark_q      <= 4'h0;
            k_q         <= 2'd0;
            order_err_q <= |unsorted;
            state_q     <= SCATTER;
          end
        end
        SCATTER: begin
          out_data_q <= out_data_d;
          mark_q     <= mark_d;
          k_q        <= k_q + 2'd1;
          if (k_q == 2'd3) begin
            // mark_d already includes this cycle's write.
            perm_err_q  <= (mark_d != 4'hF);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Gated by reset so the block never advertises readiness while held in reset.
  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign perm_err  = perm_err_q;
  assign order_err = order_err_q;

endmodule
